uart_trx_param: RTL and testbench

- Parametrised UART transceiver. Successor to the fixed 9600-baud, 8N1, single-character UART model.
- Adds a programmable baud divider with 16x oversampled mid-bit receive sampling, configurable frame format (data bits, parity, stop bits), and a valid/ready TX handshake.
- Adds a buffered RX path (FIFO) with parity, framing and overflow error reporting.
- Sits between the user-project bus-side UART registers and the chip serial pins. Also used as the bench-side UART partner.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_sync_fifo.sv | 50 +++++
 rtl/uart_trx_param.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_trx_param.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transceiver.
package uart_pkg;

    localparam int unsigned OS_RATE = 16;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;

    // Oversampling tick divider; clamped so a too-fast baud still yields a legal counter.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        int unsigned div;
        div = clk_freq / (baud * OS_RATE);
        return (div < 1) ? 1 : div;
    endfunction

    // RX FIFO entry: {frame_err, parity_err, data}.
    function automatic int unsigned entry_width(input int unsigned data_bits);
        return data_bits + 2;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy count.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullLevel = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == FullLevel);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];
    assign level   = level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      level_q <= level_q + 1'b1;
            else if (do_pop && !do_push) level_q <= level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_trx_param.sv
// UART transceiver: shared 16x tick, oversampled RX into a FWFT FIFO, handshaked TX.
module uart_trx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 40000000,
    parameter int unsigned BAUD          = 9600,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned PARITY_EN     = 0,
    parameter int unsigned PARITY_ODD    = 0,
    parameter int unsigned STOP_BITS     = 1,
    parameter int unsigned RX_FIFO_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ser_rx,
    output logic                             ser_tx,
    input  logic [DATA_BITS-1:0]             tx_data,
    input  logic                             tx_valid,
    output logic                             tx_ready,
    output logic                             tx_busy,
    output logic [DATA_BITS-1:0]             rx_data,
    output logic                             rx_parity_err,
    output logic                             rx_frame_err,
    output logic                             rx_valid,
    input  logic                             rx_ready,
    output logic [$clog2(RX_FIFO_DEPTH):0]   rx_level,
    output logic                             rx_overflow,
    input  logic                             ovf_clear
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned EW  = entry_width(DATA_BITS);
    localparam logic [CW-1:0] TickMax  = CW'(DIV - 1);
    localparam logic [2:0]    LastBit  = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LastStop = 3'(STOP_BITS - 1);
    localparam logic          ParEn    = (PARITY_EN != 0);
    localparam logic          ParOdd   = (PARITY_ODD != 0);

    logic [CW-1:0] tick_cnt_q;
    logic          os_tick;
    logic [1:0]    sync_q;
    logic          rx_s;

    assign os_tick = (tick_cnt_q == TickMax);
    assign rx_s    = sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
            sync_q     <= 2'b11;
        end else begin
            tick_cnt_q <= os_tick ? '0 : tick_cnt_q + 1'b1;
            sync_q     <= {sync_q[0], ser_rx};
        end
    end

    rx_state_e            rx_state_q, rx_state_d;
    logic [3:0]           rx_cnt_q, rx_cnt_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_break_q, rx_break_d;
    logic                 rx_sample, rx_push, rx_ferr, rx_pop, fifo_full, fifo_empty;
    logic [EW-1:0]        fifo_rdata;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_perr_d  = rx_perr_q;
        rx_break_d = rx_break_q;
        rx_push    = 1'b0;
        rx_ferr    = 1'b0;
        rx_sample  = os_tick && (rx_cnt_q == 4'd15);
        if (os_tick && rx_state_q != RX_IDLE) rx_cnt_d = rx_cnt_q + 4'd1;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                // After a break, wait for the line to return high before hunting a start bit.
                if (rx_break_q) begin
                    if (rx_s) rx_break_d = 1'b0;
                end else if (!rx_s) begin
                    rx_state_d = RX_START;
                    rx_bit_d   = '0;
                    rx_perr_d  = 1'b0;
                end
            end
            RX_START: begin
                if (os_tick && rx_cnt_q == 4'd7) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_sample) begin
                    rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == LastBit) rx_state_d = ParEn ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: begin
                if (rx_sample) begin
                    rx_perr_d  = rx_s != ((^rx_shift_q) ^ ParOdd);
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_sample) begin
                    rx_ferr    = !rx_s;
                    rx_push    = 1'b1;
                    rx_break_d = !rx_s;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_perr_q   <= 1'b0;
            rx_break_q  <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_perr_q  <= rx_perr_d;
            rx_break_q <= rx_break_d;
            if (rx_push && fifo_full && !rx_pop) rx_overflow <= 1'b1;
            else if (ovf_clear)                  rx_overflow <= 1'b0;
        end
    end

    assign rx_valid = !fifo_empty;
    assign rx_pop   = rx_valid && rx_ready;

    uart_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .wdata ({rx_ferr, rx_perr_q, rx_shift_q}),
        .pop   (rx_pop),
        .rdata (fifo_rdata),
        .level (rx_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rx_data       = fifo_rdata[DATA_BITS-1:0];
    assign rx_parity_err = fifo_rdata[DATA_BITS];
    assign rx_frame_err  = fifo_rdata[DATA_BITS+1];

    tx_state_e            tx_state_q, tx_state_d;
    logic [3:0]           tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_bit_end, ser_tx_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_bit_end = os_tick && (tx_cnt_q == 4'd15);
        if (os_tick && tx_state_q != TX_IDLE) tx_cnt_d = tx_cnt_q + 4'd1;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_bit_d = '0;
                if (tx_valid) begin
                    tx_shift_d = tx_data;
                    tx_par_d   = (^tx_data) ^ ParOdd;
                    tx_state_d = TX_START;
                end
            end
            TX_START: if (tx_bit_end) tx_state_d = TX_DATA;
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == LastBit) begin
                        tx_bit_d   = '0;
                        tx_state_d = ParEn ? TX_PARITY : TX_STOP;
                    end
                end
            end
            TX_PARITY: if (tx_bit_end) tx_state_d = TX_STOP;
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == LastStop) tx_state_d = TX_IDLE;
                    else                      tx_bit_d   = tx_bit_q + 3'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // Pin value is decoded from the next state so it is registered in step with the FSM.
        case (tx_state_d)
            TX_START:  ser_tx_d = 1'b0;
            TX_DATA:   ser_tx_d = tx_shift_d[0];
            TX_PARITY: ser_tx_d = tx_par_d;
            default:   ser_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            ser_tx     <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            ser_tx     <= ser_tx_d;
        end
    end

    assign tx_ready = (tx_state_q == TX_IDLE);
    assign tx_busy  = !tx_ready;

endmodule

// File: tb/tb_uart_trx_param.sv
// Directed bench: an 8N1 instance for TX waveform checks and an 8E1 instance for RX/FIFO paths.
module tb_uart_trx_param;

    localparam int unsigned CF = 1600000;
    localparam int unsigned BR = 100000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    int         checks = 0;
    int         failures = 0;

    logic       n_ser_tx, n_tx_valid, n_tx_ready, n_tx_busy;
    logic       n_rx_valid, n_perr, n_ferr, n_ovf;
    logic [7:0] n_tx_data, n_rx_data;
    logic [3:0] n_level;

    logic       e_ser_rx, e_ser_tx, e_tx_valid, e_tx_ready, e_tx_busy;
    logic       e_rx_valid, e_rx_ready, e_perr, e_ferr, e_ovf, e_ovf_clear;
    logic [7:0] e_tx_data, e_rx_data;
    logic [3:0] e_level;
    logic       loop_en, drv_rx;

    assign e_ser_rx = loop_en ? e_ser_tx : drv_rx;

    uart_trx_param #(
        .CLK_FREQ (CF), .BAUD (BR), .DATA_BITS (8), .PARITY_EN (0),
        .PARITY_ODD (0), .STOP_BITS (1), .RX_FIFO_DEPTH (8)
    ) u_n81 (
        .clk (clk), .rst (rst), .ser_rx (1'b1), .ser_tx (n_ser_tx),
        .tx_data (n_tx_data), .tx_valid (n_tx_valid), .tx_ready (n_tx_ready),
        .tx_busy (n_tx_busy), .rx_data (n_rx_data), .rx_parity_err (n_perr),
        .rx_frame_err (n_ferr), .rx_valid (n_rx_valid), .rx_ready (1'b0),
        .rx_level (n_level), .rx_overflow (n_ovf), .ovf_clear (1'b0)
    );

    uart_trx_param #(
        .CLK_FREQ (CF), .BAUD (BR), .DATA_BITS (8), .PARITY_EN (1),
        .PARITY_ODD (0), .STOP_BITS (1), .RX_FIFO_DEPTH (8)
    ) u_e81 (
        .clk (clk), .rst (rst), .ser_rx (e_ser_rx), .ser_tx (e_ser_tx),
        .tx_data (e_tx_data), .tx_valid (e_tx_valid), .tx_ready (e_tx_ready),
        .tx_busy (e_tx_busy), .rx_data (e_rx_data), .rx_parity_err (e_perr),
        .rx_frame_err (e_ferr), .rx_valid (e_rx_valid), .rx_ready (e_rx_ready),
        .rx_level (e_level), .rx_overflow (e_ovf), .ovf_clear (e_ovf_clear)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one 8E1 frame from a negedge; optionally pops in the cycle of the RX push.
    task automatic drive_frame(input logic [7:0] d, input logic par, input logic stop,
                               input logic pop_at_push);
        logic [10:0] bits;
        bits = {stop, par, d, 1'b0};
        for (int c = 0; c < 176; c++) begin
            drv_rx     = bits[c/16];
            e_rx_ready = pop_at_push && (c == 170);
            @(negedge clk);
        end
        drv_rx     = 1'b1;
        e_rx_ready = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_head();
        e_rx_ready = 1'b1;
        @(negedge clk);
        e_rx_ready = 1'b0;
    endtask

    task automatic send_tx(input logic [7:0] d);
        int n = 0;
        while (!e_tx_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("tx_ready_wait", {31'd0, e_tx_ready}, 32'd1);
        e_tx_data  = d;
        e_tx_valid = 1'b1;
        @(negedge clk);
        chk($sformatf("tx_accept_%02h", d), {31'd0, e_tx_ready}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] exp_bits;
        logic [7:0] w;
        logic [7:0] exp_q [8];
        int         busy_cnt, ready_lo, peak, n;

        rst = 1'b1; n_tx_data = '0; n_tx_valid = 1'b0; e_tx_data = '0; e_tx_valid = 1'b0;
        e_rx_ready = 1'b0; e_ovf_clear = 1'b0; loop_en = 1'b0; drv_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_ser_tx", {31'd0, e_ser_tx}, 32'd1);
        chk("rst_n81_ser_tx", {31'd0, n_ser_tx}, 32'd1);
        chk("rst_tx_ready", {31'd0, e_tx_ready}, 32'd1);
        chk("rst_tx_busy", {31'd0, e_tx_busy}, 32'd0);
        chk("rst_rx_valid", {31'd0, e_rx_valid}, 32'd0);
        chk("rst_rx_level", {28'd0, e_level}, 32'd0);
        chk("rst_overflow", {31'd0, e_ovf}, 32'd0);
        chk("rst_rx_head", {22'd0, e_ferr, e_perr, e_rx_data}, 32'd0);

        // 8N1 transmit of 0xA5
        n_tx_data  = 8'hA5;
        n_tx_valid = 1'b1;
        @(negedge clk);
        n_tx_valid = 1'b0;
        exp_bits = {1'b1, 8'hA5, 1'b0};
        busy_cnt = 0;
        ready_lo = 0;
        for (int i = 0; i < 160; i++) begin
            if (n_tx_busy) busy_cnt++;
            if (!n_tx_ready) ready_lo++;
            if (i % 16 == 8 || i == 0)
                chk($sformatf("n81_bit%0d_t%0d", i / 16, i), {31'd0, n_ser_tx},
                    {31'd0, exp_bits[i/16]});
            @(negedge clk);
        end
        chk("n81_busy_cycles", busy_cnt, 160);
        chk("n81_ready_low_cycles", ready_lo, 160);
        chk("n81_end_busy", {31'd0, n_tx_busy}, 32'd0);
        chk("n81_end_ready", {31'd0, n_tx_ready}, 32'd1);
        chk("n81_end_line", {31'd0, n_ser_tx}, 32'd1);

        // 8E1 loopback, back-to-back words
        loop_en = 1'b1;
        send_tx(8'h00);
        send_tx(8'hFF);
        send_tx(8'h3C);
        e_tx_valid = 1'b0;
        peak = 0;
        for (int i = 0; i < 400; i++) begin
            if (int'(e_level) > peak) peak = int'(e_level);
            @(negedge clk);
        end
        chk("loop_peak_level", peak, 3);
        exp_q[0] = 8'h00; exp_q[1] = 8'hFF; exp_q[2] = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("loop_data%0d", i), {24'd0, e_rx_data}, {24'd0, exp_q[i]});
            chk($sformatf("loop_flags%0d", i), {30'd0, e_ferr, e_perr}, 32'd0);
            pop_head();
        end
        chk("loop_drained", {28'd0, e_level}, 32'd0);
        loop_en = 1'b0;

        // Wrong parity bit on 0x01 (even parity would be 1)
        drive_frame(8'h01, 1'b0, 1'b1, 1'b0);
        chk("perr_level", {28'd0, e_level}, 32'd1);
        chk("perr_data", {24'd0, e_rx_data}, 32'h01);
        chk("perr_flags", {30'd0, e_ferr, e_perr}, 32'd1);
        pop_head();

        // Stop bit low on 0x55 with correct parity
        drive_frame(8'h55, 1'b0, 1'b0, 1'b0);
        chk("ferr_level", {28'd0, e_level}, 32'd1);
        chk("ferr_data", {24'd0, e_rx_data}, 32'h55);
        chk("ferr_flags", {30'd0, e_ferr, e_perr}, 32'd2);
        pop_head();

        // 4-clk glitch must be rejected as a false start
        drv_rx = 1'b0;
        repeat (4) @(negedge clk);
        drv_rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_level", {28'd0, e_level}, 32'd0);
        chk("glitch_valid", {31'd0, e_rx_valid}, 32'd0);

        // Overflow: nine frames into an 8-deep FIFO
        for (int i = 0; i < 9; i++) begin
            w = 8'hC0 + 8'(i);
            drive_frame(w, ^w, 1'b1, 1'b0);
        end
        chk("ovf_level", {28'd0, e_level}, 32'd8);
        chk("ovf_flag", {31'd0, e_ovf}, 32'd1);
        chk("ovf_head", {24'd0, e_rx_data}, 32'hC0);
        e_ovf_clear = 1'b1;
        @(negedge clk);
        e_ovf_clear = 1'b0;
        chk("ovf_cleared", {31'd0, e_ovf}, 32'd0);

        w = 8'hC9;
        drive_frame(w, ^w, 1'b1, 1'b1);
        chk("full_pushpop_level", {28'd0, e_level}, 32'd8);
        chk("full_pushpop_no_ovf", {31'd0, e_ovf}, 32'd0);
        for (int i = 0; i < 7; i++) exp_q[i] = 8'hC1 + 8'(i);
        exp_q[7] = 8'hC9;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_order%0d", i), {24'd0, e_rx_data}, {24'd0, exp_q[i]});
            pop_head();
        end
        chk("ovf_drained", {28'd0, e_level}, 32'd0);

        // Async reset in the middle of a TX data bit, with a word queued in RX
        w = 8'h33;
        drive_frame(w, ^w, 1'b1, 1'b0);
        chk("pre_rst_level", {28'd0, e_level}, 32'd1);
        e_tx_data  = 8'h5A;
        e_tx_valid = 1'b1;
        @(negedge clk);
        e_tx_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_rst_ser_tx", {31'd0, e_ser_tx}, 32'd0);
        rst = 1'b1;
        #1;
        chk("arst_ser_tx", {31'd0, e_ser_tx}, 32'd1);
        chk("arst_tx_ready", {31'd0, e_tx_ready}, 32'd1);
        chk("arst_tx_busy", {31'd0, e_tx_busy}, 32'd0);
        chk("arst_level", {28'd0, e_level}, 32'd0);
        chk("arst_rx_valid", {31'd0, e_rx_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        loop_en = 1'b1;
        send_tx(8'h96);
        e_tx_valid = 1'b0;
        n = 0;
        while (!e_rx_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("post_rst_rx_valid", {31'd0, e_rx_valid}, 32'd1);
        chk("post_rst_data", {24'd0, e_rx_data}, 32'h96);
        chk("post_rst_flags", {30'd0, e_ferr, e_perr}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
